// File: rtl/tage_update.sv
// TAGE update: queues committed branch records and turns each into
// registered base/tagged table writes, allocation and u-bit aging.
// Ports: commit_* record in (valid/ready), pause stalls dequeue,
// tw_*/bw_* table write ports, flush_ubits_hi/lo aging pulses.
module tage_update #(
  parameter int UCTR_W = 18,
  parameter int FIFO_D = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic        commit_taken,
  input  logic        commit_mispred,
  input  logic        commit_altpred,
  input  logic [2:0]  commit_provider,
  input  logic [2:0]  commit_ctr,
  input  logic [1:0]  commit_base_ctr,
  input  logic [7:0]  commit_u,
  input  logic [39:0] commit_index,
  input  logic [31:0] commit_tag,
  input  logic [11:0] commit_base_index,
  output logic [3:0]  tw_valid,
  output logic [39:0] tw_index,
  output logic [31:0] tw_tag,
  output logic [11:0] tw_ctr,
  output logic [7:0]  tw_u,
  output logic        bw_valid,
  output logic [11:0] bw_index,
  output logic [1:0]  bw_ctr,
  output logic        flush_ubits_hi,
  output logic        flush_ubits_lo
);

  localparam int AW = $clog2(FIFO_D);
  localparam logic [AW:0] DEPTH = FIFO_D[AW:0];

  typedef struct packed {
    logic        taken;
    logic        mispred;
    logic        altpred;
    logic [2:0]  provider;
    logic [2:0]  ctr;
    logic [1:0]  base_ctr;
    logic [7:0]  u;
    logic [39:0] index;
    logic [31:0] tag;
    logic [11:0] base_index;
  } rec_t;

  function automatic logic [2:0] up3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction
  function automatic logic [2:0] dn3(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction
  function automatic logic [1:0] up2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction
  function automatic logic [1:0] dn2(input logic [1:0] v);
    return (v == 2'd0) ? v : v - 2'd1;
  endfunction

  rec_t              mem [FIFO_D];
  rec_t              in_rec;
  rec_t              head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [UCTR_W-1:0] age;
  logic              phase;
  logic [7:0]        lfsr;
  logic              enq;
  logic              deq;
  logic              wrap;

  assign in_rec = '{
    taken: commit_taken, mispred: commit_mispred,
    altpred: commit_altpred, provider: commit_provider,
    ctr: commit_ctr, base_ctr: commit_base_ctr, u: commit_u,
    index: commit_index, tag: commit_tag,
    base_index: commit_base_index
  };
  assign head         = mem[rd_ptr];
  assign commit_ready = (count != DEPTH);
  assign enq          = commit_valid && commit_ready;
  assign deq          = (count != '0) && !pause;
  assign wrap         = &age;

  logic [3:0]  cand, first, rest, second, alloc;
  logic        pred, do_alloc;
  logic [3:0]  n_tv;
  logic [39:0] n_ti;
  logic [31:0] n_tt;
  logic [11:0] n_tc;
  logic [7:0]  n_tu;
  logic        n_bv;
  logic [11:0] n_bi;
  logic [1:0]  n_bc;

  always_comb begin
    n_tv = '0;
    n_ti = '0;
    n_tt = '0;
    n_tc = '0;
    n_tu = '0;
    n_bv = 1'b0;
    n_bi = '0;
    n_bc = '0;
    cand = '0;
    for (int t = 0; t < 4; t++) begin
      if (3'(t + 1) > head.provider && head.u[2*t +: 2] == 2'd0)
        cand[t] = 1'b1;
    end
    // isolate lowest and second-lowest candidate bits
    first    = cand & (~cand + 4'd1);
    rest     = cand & ~first;
    second   = rest & (~rest + 4'd1);
    alloc    = (rest != '0 && lfsr[0]) ? second : first;
    pred     = head.ctr[2];
    do_alloc = head.mispred && head.provider < 3'd4;
    if (deq) begin
      if (head.provider == 3'd0) begin
        n_bv = 1'b1;
        n_bi = head.base_index;
        n_bc = head.taken ? up2(head.base_ctr)
                          : dn2(head.base_ctr);
      end
      for (int t = 0; t < 4; t++) begin
        if (3'(t + 1) == head.provider) begin
          n_tv[t]        = 1'b1;
          n_ti[10*t +: 10] = head.index[10*t +: 10];
          n_tt[8*t +: 8]   = head.tag[8*t +: 8];
          n_tc[3*t +: 3]   = head.taken ? up3(head.ctr)
                                        : dn3(head.ctr);
          if (pred == head.altpred)
            n_tu[2*t +: 2] = head.u[2*t +: 2];
          else if (pred == head.taken)
            n_tu[2*t +: 2] = up2(head.u[2*t +: 2]);
          else
            n_tu[2*t +: 2] = dn2(head.u[2*t +: 2]);
        end else if (do_alloc && 3'(t + 1) > head.provider) begin
          if (cand == '0) begin
            // nothing free: age every longer-history entry
            n_tv[t]          = 1'b1;
            n_ti[10*t +: 10] = head.index[10*t +: 10];
            n_tt[8*t +: 8]   = head.tag[8*t +: 8];
            n_tc[3*t +: 3]   = head.ctr;
            n_tu[2*t +: 2]   = dn2(head.u[2*t +: 2]);
          end else if (alloc[t]) begin
            n_tv[t]          = 1'b1;
            n_ti[10*t +: 10] = head.index[10*t +: 10];
            n_tt[8*t +: 8]   = head.tag[8*t +: 8];
            n_tc[3*t +: 3]   = head.taken ? 3'b100 : 3'b011;
            n_tu[2*t +: 2]   = 2'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      age            <= '0;
      phase          <= 1'b0;
      lfsr           <= 8'hA5;
      tw_valid       <= '0;
      tw_index       <= '0;
      tw_tag         <= '0;
      tw_ctr         <= '0;
      tw_u           <= '0;
      bw_valid       <= 1'b0;
      bw_index       <= '0;
      bw_ctr         <= '0;
      flush_ubits_hi <= 1'b0;
      flush_ubits_lo <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      tw_valid       <= n_tv;
      tw_index       <= n_ti;
      tw_tag         <= n_tt;
      tw_ctr         <= n_tc;
      tw_u           <= n_tu;
      bw_valid       <= n_bv;
      bw_index       <= n_bi;
      bw_ctr         <= n_bc;
      flush_ubits_hi <= deq && wrap && !phase;
      flush_ubits_lo <= deq && wrap && phase;
      if (deq) begin
        age <= age + UCTR_W'(1);
        if (wrap) phase <= ~phase;
        if (head.mispred)
          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
    end
  end

endmodule

// File: tb/tb_tage_update.sv
// Bench for tage_update: directed cases plus random traffic checked
// against a queue-based reference model of the update rules.
module tb_tage_update;
  localparam int UW = 2;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic        commit_valid;
  logic        commit_ready;
  logic        commit_taken;
  logic        commit_mispred;
  logic        commit_altpred;
  logic [2:0]  commit_provider;
  logic [2:0]  commit_ctr;
  logic [1:0]  commit_base_ctr;
  logic [7:0]  commit_u;
  logic [39:0] commit_index;
  logic [31:0] commit_tag;
  logic [11:0] commit_base_index;
  logic [3:0]  tw_valid;
  logic [39:0] tw_index;
  logic [31:0] tw_tag;
  logic [11:0] tw_ctr;
  logic [7:0]  tw_u;
  logic        bw_valid;
  logic [11:0] bw_index;
  logic [1:0]  bw_ctr;
  logic        flush_ubits_hi;
  logic        flush_ubits_lo;

  always #5 clk = ~clk;

  tage_update #(.UCTR_W(UW), .FIFO_D(D)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_taken(commit_taken), .commit_mispred(commit_mispred),
    .commit_altpred(commit_altpred),
    .commit_provider(commit_provider), .commit_ctr(commit_ctr),
    .commit_base_ctr(commit_base_ctr), .commit_u(commit_u),
    .commit_index(commit_index), .commit_tag(commit_tag),
    .commit_base_index(commit_base_index),
    .tw_valid(tw_valid), .tw_index(tw_index), .tw_tag(tw_tag),
    .tw_ctr(tw_ctr), .tw_u(tw_u),
    .bw_valid(bw_valid), .bw_index(bw_index), .bw_ctr(bw_ctr),
    .flush_ubits_hi(flush_ubits_hi), .flush_ubits_lo(flush_ubits_lo)
  );

  typedef struct packed {
    logic        taken;
    logic        mis;
    logic        alt;
    logic [2:0]  prov;
    logic [2:0]  ctr;
    logic [1:0]  bctr;
    logic [7:0]  u;
    logic [39:0] idx;
    logic [31:0] tag;
    logic [11:0] bidx;
  } rec_t;

  typedef struct packed {
    logic [3:0]  tv;
    logic [39:0] ti;
    logic [31:0] tt;
    logic [11:0] tc;
    logic [7:0]  tu;
    logic        bv;
    logic [11:0] bi;
    logic [1:0]  bc;
    logic        fh;
    logic        fl;
  } wr_t;

  rec_t       q[$];
  wr_t        exp;
  logic [7:0] lfsr;
  int         aging;
  bit         phase;
  int         passed = 0;
  int         total  = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  task automatic check_out();
    chk("tw_valid", 128'(tw_valid), 128'(exp.tv));
    chk("tw_index", 128'(tw_index), 128'(exp.ti));
    chk("tw_tag",   128'(tw_tag),   128'(exp.tt));
    chk("tw_ctr",   128'(tw_ctr),   128'(exp.tc));
    chk("tw_u",     128'(tw_u),     128'(exp.tu));
    chk("bw", 128'({bw_valid, bw_index, bw_ctr}),
        128'({exp.bv, exp.bi, exp.bc}));
    chk("flush", 128'({flush_ubits_hi, flush_ubits_lo}),
        128'({exp.fh, exp.fl}));
  endtask

  function automatic int clamp(int v, int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  task automatic compute(rec_t r);
    wr_t e;
    int  p, c, uu, pick;
    int  cands[$];
    e = '0;
    p = int'(r.prov);
    if (p == 0) begin
      c = int'(r.bctr) + (r.taken ? 1 : -1);
      e.bv = 1'b1;
      e.bi = r.bidx;
      e.bc = 2'(clamp(c, 3));
    end else begin
      c  = int'(r.ctr) + (r.taken ? 1 : -1);
      uu = int'(r.u[(p-1)*2 +: 2]);
      if (r.ctr[2] != r.alt) uu += (r.ctr[2] == r.taken) ? 1 : -1;
      e.tv[p-1] = 1'b1;
      e.ti[(p-1)*10 +: 10] = r.idx[(p-1)*10 +: 10];
      e.tt[(p-1)*8 +: 8]   = r.tag[(p-1)*8 +: 8];
      e.tc[(p-1)*3 +: 3]   = 3'(clamp(c, 7));
      e.tu[(p-1)*2 +: 2]   = 2'(clamp(uu, 3));
    end
    if (r.mis) begin
      if (p < 4) begin
        for (int j = p + 1; j <= 4; j++)
          if (r.u[(j-1)*2 +: 2] == 2'd0) cands.push_back(j);
        if (cands.size() == 0) begin
          for (int j = p + 1; j <= 4; j++) begin
            e.tv[j-1] = 1'b1;
            e.ti[(j-1)*10 +: 10] = r.idx[(j-1)*10 +: 10];
            e.tt[(j-1)*8 +: 8]   = r.tag[(j-1)*8 +: 8];
            e.tc[(j-1)*3 +: 3]   = r.ctr;
            e.tu[(j-1)*2 +: 2] =
              2'(clamp(int'(r.u[(j-1)*2 +: 2]) - 1, 3));
          end
        end else begin
          pick = (cands.size() >= 2 && lfsr[0]) ? cands[1] : cands[0];
          e.tv[pick-1] = 1'b1;
          e.ti[(pick-1)*10 +: 10] = r.idx[(pick-1)*10 +: 10];
          e.tt[(pick-1)*8 +: 8]   = r.tag[(pick-1)*8 +: 8];
          e.tc[(pick-1)*3 +: 3]   = r.taken ? 3'b100 : 3'b011;
          e.tu[(pick-1)*2 +: 2]   = 2'd0;
        end
      end
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    aging++;
    if (aging % (1 << UW) == 0) begin
      if (!phase) e.fh = 1'b1;
      else        e.fl = 1'b1;
      phase = !phase;
    end
    exp = e;
  endtask

  task automatic drive(bit v, rec_t r);
    commit_valid      = v;
    commit_taken      = r.taken;
    commit_mispred    = r.mis;
    commit_altpred    = r.alt;
    commit_provider   = r.prov;
    commit_ctr        = r.ctr;
    commit_base_ctr   = r.bctr;
    commit_u          = r.u;
    commit_index      = r.idx;
    commit_tag        = r.tag;
    commit_base_index = r.bidx;
  endtask

  task automatic step(bit v, rec_t r, bit p);
    bit   acc, dq;
    rec_t h;
    drive(v, r);
    pause = p;
    #1;
    chk("ready", 128'(commit_ready), 128'(q.size() < D));
    acc = v && q.size() < D;
    dq  = q.size() > 0 && !p;
    @(posedge clk);
    if (dq) begin
      h = q.pop_front();
      compute(h);
    end else begin
      exp = '0;
    end
    if (acc) q.push_back(r);
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    exp   = '0;
    lfsr  = 8'hA5;
    aging = 0;
    phase = 1'b0;
    #2;
    check_out();
    chk("reset_ready", 128'(commit_ready), 128'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.taken = 1'($urandom_range(0, 1));
    r.mis   = ($urandom_range(0, 9) < 4);
    r.alt   = 1'($urandom_range(0, 1));
    r.prov  = 3'($urandom_range(0, 4));
    r.ctr   = 3'($urandom);
    r.bctr  = 2'($urandom);
    for (int t = 0; t < 4; t++)
      r.u[2*t +: 2] = ($urandom_range(0, 2) == 0) ? 2'd0
                                                  : 2'($urandom);
    r.idx  = 40'({$urandom, $urandom});
    r.tag  = $urandom;
    r.bidx = 12'($urandom);
    return r;
  endfunction

  rec_t idle, r;

  initial begin
    idle = '0;
    pause = 1'b0;
    drive(1'b0, idle);
    do_reset();

    r = rand_rec();
    r.prov = 3'd0; r.bctr = 2'd3; r.taken = 1'b1; r.mis = 1'b0;
    step(1'b1, r, 1'b0);
    step(1'b0, idle, 1'b0);
    chk("r031_bv", 128'(bw_valid), 128'(1));
    chk("r031_bctr", 128'(bw_ctr), 128'(3));
    chk("r031_tv", 128'(tw_valid), 128'(0));

    r = rand_rec();
    r.prov = 3'd2; r.ctr = 3'b011; r.alt = 1'b0;
    r.taken = 1'b1; r.mis = 1'b0; r.u = 8'h04;
    step(1'b1, r, 1'b0);
    step(1'b0, idle, 1'b0);
    chk("r032_tv", 128'(tw_valid), 128'(4'b0010));
    chk("r032_ctr", 128'(tw_ctr[5:3]), 128'(4));

    r = rand_rec();
    r.prov = 3'd1; r.mis = 1'b1; r.taken = 1'b1;
    r.ctr = 3'b010; r.u = 8'h02;
    step(1'b1, r, 1'b0);
    step(1'b0, idle, 1'b0);
    chk("r033_tv", 128'(tw_valid[3:1]), 128'(3'b010));
    chk("r033_ctr", 128'(tw_ctr[8:6]), 128'(3'b100));
    chk("r033_u", 128'(tw_u[5:4]), 128'(0));

    r = rand_rec();
    r.prov = 3'd1; r.mis = 1'b1; r.u = 8'hAA;
    step(1'b1, r, 1'b0);
    step(1'b0, idle, 1'b0);
    chk("r034_tv", 128'(tw_valid), 128'(4'b1111));
    chk("r034_u", 128'(tw_u[7:2]), 128'(6'b010101));

    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, rand_rec(), 1'b1);
    chk("r035_full", 128'(commit_ready), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, idle, 1'b0);
      chk("r035_burst", 128'((|tw_valid) | bw_valid), 128'(1));
    end
    step(1'b0, idle, 1'b0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(i < 8, rand_rec(), 1'b0);
      chk("r036_hi", 128'(flush_ubits_hi), 128'(i == 4));
      chk("r036_lo", 128'(flush_ubits_lo), 128'(i == 8));
    end

    for (int i = 0; i < 3; i++) step(1'b1, rand_rec(), 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, rand_rec(),
           $urandom_range(0, 9) < 3);
    for (int i = 0; i < 8; i++) step(1'b0, idle, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
